alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequential issue/writeback controller sitting directly upstream of the 16-bit combinational ALU.
- Accepts packed instructions over a valid/ready handshake and reads two operands from an internal 8-entry register file.
- Drives registered A/B/alu_code to the ALU, captures C/overflow, and writes the result back to the register file.
- Maintains sticky overflow and illegal-opcode status flags.

Parameters:
- DATA_W, 16, operand/result width; must match the ALU.
- NREG, 8, register file depth.
- AW, 3, register address width (log2 NREG).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept an instruction (high only in IDLE)
- instr  in  16  [15:11] alu_code, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] reserved (ignored)
- ld_en  in  1  external register load strobe
- ld_addr  in  AW  load target
- ld_data  in  DATA_W  load value
- obs_addr  in  AW  observation read address
- obs_data  out  DATA_W  combinational read of reg[obs_addr]
- alu_a  out  DATA_W  registered operand A to ALU
- alu_b  out  DATA_W  registered operand B to ALU
- alu_code  out  5  registered opcode to ALU
- alu_c  in  DATA_W  ALU result
- alu_ovf  in  1  ALU overflow
- done  out  1  one-cycle pulse when an instruction retires (legal or illegal)
- ovf_flag  out  1  sticky overflow
- ill_flag  out  1  sticky illegal opcode
- clr_flags  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All registers cleared to 0: alu_a, alu_b, alu_code, regfile, result latch.
  - done=0, ovf_flag=0, ill_flag=0.
  - instr_ready=1 once rst deasserts.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid && instr_ready, on that edge:
    - alu_a<=reg[rs1], alu_b<=reg[rs2], alu_code<=instr[15:11].
    - Latch rd and a legal bit; go to EXEC.
- EXEC:
  - instr_ready=0. ALU output settles combinationally.
  - On the edge, latch res<=alu_c and ovf_l<=alu_ovf; go to WB.
- WB:
  - If legal: reg[rd]<=res and ovf_flag|=ovf_l.
  - If illegal: no regfile write; ill_flag<=1.
  - done=1 for exactly this cycle; next state IDLE.
- Latency: accept edge → done asserted 2 cycles later. Throughput is 1 instruction per 3 cycles.
- alu_a, alu_b and alu_code hold their values after WB until the next accept.
- Legal opcodes:
  - 00xxx: all 8.
  - 01{000,001,010,100}.
  - 10{000,001,010,011}.
  - 11{000..101}.
  - Anything else is illegal.
- Illegal opcodes are still driven to the ALU, so timing is identical to a legal instruction.
- Hazards: rs1/rs2 equal to a previous rd read the updated value, because WB completes before the next accept. No forwarding is needed.
- rd==rs1/rs2 within one instruction: operands are read at accept, then rd is written at WB. This is legal.
- ld_en:
  - Honoured only in IDLE; ignored in EXEC/WB with no error.
  - In IDLE, same-cycle ld_en and instruction accept: the load is written, and operand reads see the pre-load (old) value.
- clr_flags:
  - Clears both sticky flags on the edge.
  - If simultaneous with a WB that would set a flag, set wins.
- instr_valid with reserved bits nonzero: the bits are ignored, not illegal.
- Reset mid-operation (EXEC/WB): the in-flight instruction is discarded, no write occurs, and done is not pulsed.
- obs_data is purely combinational from the regfile. A write is visible the cycle after its edge.

Decomposition:
- Shared package holds:
  - Opcode field constants: OP_ARITH=2'b00, OP_LOGIC=2'b01, OP_SHIFT=2'b10, OP_CMP=2'b11.
  - Instruction field bit positions.
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, WB=2'd2.
  - An is_legal_op function.
- One sub-module, alu_regfile: NREG×DATA_W, two combinational read ports plus the observation port, one write port muxed between WB and ld.

Test Plan:
- Reset with rst mid-EXEC → no write, done never pulses, all outputs 0, instr_ready=1 after release.
- ld r1=0x0005, r2=0x0003; issue alu_code=00000 (add), rd=3 → alu_a=0x0005, alu_b=0x0003 on the cycle after accept; done 2 cycles after accept; obs r3=0x0008 (ALU model adds).
- ld r1=0x7FFF, r2=0x0001; add with ALU overflow → ovf_flag=1 and stays 1; clr_flags → 0. Simultaneous clr_flags+overflow WB → 1.
- Issue alu_code=01011 (illegal), rd=4 holding 0x1234 → done pulses, ill_flag=1, r4 still 0x1234.
- Back-to-back: instr_valid held high with two instructions, second reads the first's rd → instr_ready low in EXEC/WB, second accepted in IDLE 3 cycles after the first, operand equals the first's result.
- ld_en to r2 during EXEC → ignored, r2 unchanged; ld_en in the same IDLE cycle as an accept reading r2 → old value issued, new value stored.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback controller.
// Covers the instruction field positions, the opcode groups, the FSM encoding and the opcode legality check.
package alu_issue_ctrl_pkg;

  localparam logic [1:0] OP_ARITH = 2'b00;
  localparam logic [1:0] OP_LOGIC = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_CMP   = 2'b11;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 5;
  localparam int RS2_MSB = 4;
  localparam int RS2_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  // Each opcode group populates a different subset of its 8 sub-codes
  function automatic logic is_legal_op(input logic [4:0] code);
    logic [2:0] sub;
    logic       ok;
    sub = code[2:0];
    case (code[4:3])
      OP_ARITH: ok = 1'b1;
      OP_LOGIC: ok = (sub == 3'd0) || (sub == 3'd1) || (sub == 3'd2) || (sub == 3'd4);
      OP_SHIFT: ok = (sub <= 3'd3);
      OP_CMP:   ok = (sub <= 3'd5);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file for the issue controller.
// It has two operand read ports, an observation read port and a single write port.
module alu_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  input  logic [AW-1:0]     obs_addr,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] obs_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1   = regs_q[raddr1];
  assign rdata2   = regs_q[raddr2];
  assign obs_data = regs_q[obs_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// This controller sits upstream of the 16-bit ALU and runs each instruction through IDLE, EXEC and WB.
// It reads the operands at accept, captures the ALU result in EXEC and writes it back in WB.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW-1:0]     obs_addr,
  output logic [DATA_W-1:0] obs_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_code,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_ovf,
  output logic              done,
  output logic              ovf_flag,
  output logic              ill_flag,
  input  logic              clr_flags
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
  logic [4:0]        alu_code_q, alu_code_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic              legal_q, legal_d, ovf_l_q, ovf_l_d;
  logic              ovf_flag_q, ovf_flag_d, ill_flag_q, ill_flag_d;

  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rdata1, rdata2;
  logic              unused_rsvd;

  assign unused_rsvd = ^instr[1:0];

  alu_regfile #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr1   (instr[RS1_MSB:RS1_LSB]),
    .raddr2   (instr[RS2_MSB:RS2_LSB]),
    .obs_addr (obs_addr),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .obs_data (obs_data)
  );

  // A flag that is cleared and set in the same cycle stays set
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_code_d = alu_code_q;
    rd_d       = rd_q;
    legal_d    = legal_q;
    res_d      = res_q;
    ovf_l_d    = ovf_l_q;
    ovf_flag_d = clr_flags ? 1'b0 : ovf_flag_q;
    ill_flag_d = clr_flags ? 1'b0 : ill_flag_q;
    rf_we      = 1'b0;
    rf_waddr   = ld_addr;
    rf_wdata   = ld_data;
    case (state_q)
      IDLE: begin
        rf_we = ld_en;
        if (instr_valid) begin
          alu_a_d    = rdata1;
          alu_b_d    = rdata2;
          alu_code_d = instr[OPC_MSB:OPC_LSB];
          rd_d       = instr[RD_MSB:RD_LSB];
          legal_d    = is_legal_op(instr[OPC_MSB:OPC_LSB]);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_c;
        ovf_l_d = alu_ovf;
        state_d = WB;
      end
      WB: begin
        if (legal_q) begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = res_q;
          if (ovf_l_q) ovf_flag_d = 1'b1;
        end else begin
          ill_flag_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_code_q <= '0;
      rd_q       <= '0;
      legal_q    <= 1'b0;
      res_q      <= '0;
      ovf_l_q    <= 1'b0;
      ovf_flag_q <= 1'b0;
      ill_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_code_q <= alu_code_d;
      rd_q       <= rd_d;
      legal_q    <= legal_d;
      res_q      <= res_d;
      ovf_l_q    <= ovf_l_d;
      ovf_flag_q <= ovf_flag_d;
      ill_flag_q <= ill_flag_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign done        = (state_q == WB);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_code    = alu_code_q;
  assign ovf_flag    = ovf_flag_q;
  assign ill_flag    = ill_flag_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl, using a behavioural ALU and a register-file reference model.
// Stimulus is a set of directed scenarios followed by a randomized instruction stream.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [2:0]  obs_addr = '0;
  logic [15:0] obs_data;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_code;
  logic        alu_ovf;
  logic        done, ovf_flag, ill_flag;
  logic        clr_flags = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state: one bit per opcode for legality, plus registers and sticky flags
  logic [31:0] legal_mask = 32'h3F0F17FF;
  logic [15:0] m_regs [8];
  logic        m_ovf, m_ill;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .obs_addr(obs_addr), .obs_data(obs_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_code(alu_code), .alu_c(alu_c), .alu_ovf(alu_ovf), .done(done),
    .ovf_flag(ovf_flag), .ill_flag(ill_flag), .clr_flags(clr_flags)
  );

  // Stand-in ALU: {ovf, result}
  function automatic logic [16:0] tb_alu(input logic [4:0] code, input logic [15:0] a, input logic [15:0] b);
    int s;
    logic [15:0] r;
    logic v;
    case (code)
      5'd0: begin s = int'($signed(a)) + int'($signed(b)); r = a + b; v = (s > 32767) || (s < -32768); end
      5'd1: begin s = int'($signed(a)) - int'($signed(b)); r = a - b; v = (s > 32767) || (s < -32768); end
      default: begin r = a ^ (b << 1) ^ {11'd0, code}; v = 1'b0; end
    endcase
    return {v, r};
  endfunction

  always_comb {alu_ovf, alu_c} = tb_alu(alu_code, alu_a, alu_b);

  function automatic logic [15:0] mk(input logic [4:0] code, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2, input logic [1:0] rsv);
    return {code, rd, rs1, rs2, rsv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_ovf = 1'b0;
    m_ill = 1'b0;
  endtask

  task automatic model_exec(input logic [15:0] ins, input bit clr);
    logic [16:0] r;
    r = tb_alu(ins[15:11], m_regs[ins[7:5]], m_regs[ins[4:2]]);
    if (clr) begin m_ovf = 1'b0; m_ill = 1'b0; end
    if (legal_mask[ins[15:11]]) begin
      m_regs[ins[10:8]] = r[15:0];
      if (r[16]) m_ovf = 1'b1;
    end else begin
      m_ill = 1'b1;
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic read_obs(input logic [2:0] a, output logic [15:0] d);
    obs_addr = a;
    #1;
    d = obs_data;
  endtask

  // Issues one instruction from IDLE and records what the DUT shows in the EXEC, WB and following IDLE cycles
  task automatic issue(input logic [15:0] ins, input bit clr_wb, output logic rdy,
                       output logic [15:0] ga, output logic [15:0] gb, output logic [4:0] gc,
                       output logic [2:0] dn);
    instr = ins; instr_valid = 1'b1;
    rdy = instr_ready;
    tick();
    instr_valid = 1'b0;
    ga = alu_a; gb = alu_b; gc = alu_code; dn[0] = done;
    tick();
    dn[1] = done;
    clr_flags = clr_wb;
    tick();
    clr_flags = 1'b0;
    dn[2] = done;
    model_exec(ins, clr_wb);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    model_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if ({alu_a, alu_b, alu_code, done, ovf_flag, ill_flag} !== 40'd0) begin n_fails++; $display("[TB] FAIL reset_outputs: got %h required 0", {alu_a, alu_b, alu_code, done, ovf_flag, ill_flag}); end
    rst = 1'b0;
    tick();
    n_checks++; if (instr_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_ready: got %b required 1", instr_ready); end
    load(3'd1, 16'h0011);
    load(3'd2, 16'h0022);
    instr = mk(5'd0, 3'd5, 3'd1, 3'd2, 2'd0); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if ({alu_a, done} !== 17'd0) begin n_fails++; $display("[TB] FAIL reset_mid_exec: got %h required 0", {alu_a, done}); end
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({done, instr_ready} !== 2'b01) begin n_fails++; $display("[TB] FAIL reset_after_release: got done/ready %b required 01", {done, instr_ready}); end
      tick();
    end
    read_obs(3'd5, v);
    n_checks++; if (v !== m_regs[5]) begin n_fails++; $display("[TB] FAIL reset_no_write: got %h required %h", v, m_regs[5]); end
  endtask

  task automatic test_add();
    logic rdy; logic [15:0] ga, gb, v; logic [4:0] gc; logic [2:0] dn;
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    issue(mk(5'd0, 3'd3, 3'd1, 3'd2, 2'd0), 1'b0, rdy, ga, gb, gc, dn);
    n_checks++; if (rdy !== 1'b1) begin n_fails++; $display("[TB] FAIL add_ready: got %b required 1", rdy); end
    n_checks++; if ({ga, gb} !== {16'h0005, 16'h0003}) begin n_fails++; $display("[TB] FAIL add_operands: got %h/%h required 0005/0003", ga, gb); end
    n_checks++; if (dn !== 3'b010) begin n_fails++; $display("[TB] FAIL add_done_timing: got %b required 010", dn); end
    read_obs(3'd3, v);
    n_checks++; if (v !== 16'h0008) begin n_fails++; $display("[TB] FAIL add_result: got %h required 0008", v); end
  endtask

  task automatic test_overflow();
    logic rdy; logic [15:0] ga, gb; logic [4:0] gc; logic [2:0] dn;
    load(3'd1, 16'h7FFF);
    load(3'd2, 16'h0001);
    issue(mk(5'd0, 3'd6, 3'd1, 3'd2, 2'd0), 1'b0, rdy, ga, gb, gc, dn);
    n_checks++; if (ovf_flag !== 1'b1) begin n_fails++; $display("[TB] FAIL ovf_set: got %b required 1", ovf_flag); end
    issue(mk(5'd0, 3'd7, 3'd0, 3'd0, 2'd0), 1'b0, rdy, ga, gb, gc, dn);
    n_checks++; if (ovf_flag !== m_ovf) begin n_fails++; $display("[TB] FAIL ovf_sticky: got %b required %b", ovf_flag, m_ovf); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    m_ovf = 1'b0; m_ill = 1'b0;
    n_checks++; if (ovf_flag !== 1'b0) begin n_fails++; $display("[TB] FAIL ovf_clear: got %b required 0", ovf_flag); end
    issue(mk(5'd0, 3'd6, 3'd1, 3'd2, 2'd0), 1'b1, rdy, ga, gb, gc, dn);
    n_checks++; if (ovf_flag !== 1'b1) begin n_fails++; $display("[TB] FAIL ovf_set_wins: got %b required 1", ovf_flag); end
  endtask

  task automatic test_illegal();
    logic rdy; logic [15:0] ga, gb, v; logic [4:0] gc; logic [2:0] dn;
    load(3'd4, 16'h1234);
    issue(mk(5'b01011, 3'd4, 3'd1, 3'd2, 2'd0), 1'b0, rdy, ga, gb, gc, dn);
    n_checks++; if (dn !== 3'b010) begin n_fails++; $display("[TB] FAIL ill_done: got %b required 010", dn); end
    n_checks++; if (gc !== 5'b01011) begin n_fails++; $display("[TB] FAIL ill_code_driven: got %b required 01011", gc); end
    n_checks++; if (ill_flag !== 1'b1) begin n_fails++; $display("[TB] FAIL ill_flag: got %b required 1", ill_flag); end
    read_obs(3'd4, v);
    n_checks++; if (v !== 16'h1234) begin n_fails++; $display("[TB] FAIL ill_no_write: got %h required 1234", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] i1, i2, v;
    load(3'd1, 16'h0003);
    load(3'd2, 16'h0004);
    i1 = mk(5'd0, 3'd3, 3'd1, 3'd2, 2'd0);
    i2 = mk(5'd0, 3'd5, 3'd3, 3'd1, 2'd0);
    instr = i1; instr_valid = 1'b1;
    tick();
    instr = i2;
    n_checks++; if ({instr_ready, done} !== 2'b00) begin n_fails++; $display("[TB] FAIL b2b_exec: got ready/done %b required 00", {instr_ready, done}); end
    tick();
    n_checks++; if ({instr_ready, done} !== 2'b01) begin n_fails++; $display("[TB] FAIL b2b_wb: got ready/done %b required 01", {instr_ready, done}); end
    tick();
    model_exec(i1, 1'b0);
    n_checks++; if ({instr_ready, done} !== 2'b10) begin n_fails++; $display("[TB] FAIL b2b_idle: got ready/done %b required 10", {instr_ready, done}); end
    tick();
    instr_valid = 1'b0;
    n_checks++; if ({alu_a, alu_b} !== {m_regs[3], m_regs[1]}) begin n_fails++; $display("[TB] FAIL b2b_operands: got %h/%h required %h/%h", alu_a, alu_b, m_regs[3], m_regs[1]); end
    repeat (2) tick();
    model_exec(i2, 1'b0);
    read_obs(3'd5, v);
    n_checks++; if (v !== m_regs[5]) begin n_fails++; $display("[TB] FAIL b2b_result: got %h required %h", v, m_regs[5]); end
  endtask

  task automatic test_ld_rules();
    logic [15:0] i1, v;
    i1 = mk(5'd0, 3'd6, 3'd0, 3'd0, 2'd0);
    instr = i1; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'hBEEF;
    tick();
    ld_en = 1'b0;
    tick();
    model_exec(i1, 1'b0);
    read_obs(3'd2, v);
    n_checks++; if (v !== m_regs[2]) begin n_fails++; $display("[TB] FAIL ld_in_exec_ignored: got %h required %h", v, m_regs[2]); end
    i1 = mk(5'd0, 3'd7, 3'd2, 3'd2, 2'd0);
    instr = i1; instr_valid = 1'b1;
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'hCAFE;
    tick();
    instr_valid = 1'b0; ld_en = 1'b0;
    n_checks++; if (alu_a !== m_regs[2]) begin n_fails++; $display("[TB] FAIL ld_accept_old_operand: got %h required %h", alu_a, m_regs[2]); end
    model_exec(i1, 1'b0);
    m_regs[2] = 16'hCAFE;
    repeat (2) tick();
    read_obs(3'd2, v);
    n_checks++; if (v !== 16'hCAFE) begin n_fails++; $display("[TB] FAIL ld_accept_stored: got %h required CAFE", v); end
    read_obs(3'd7, v);
    n_checks++; if (v !== m_regs[7]) begin n_fails++; $display("[TB] FAIL ld_accept_result: got %h required %h", v, m_regs[7]); end
  endtask

  task automatic test_random();
    logic rdy; logic [15:0] ga, gb, ins, ea, eb, v; logic [4:0] gc; logic [2:0] dn;
    bit clr;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1, 0) == 1) load(3'($urandom_range(7, 0)), 16'($urandom));
      ins = mk(5'($urandom_range(31, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
               3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)));
      if ($urandom_range(3, 0) == 0) ins[15:11] = 5'($urandom_range(1, 0));
      clr = ($urandom_range(3, 0) == 0);
      ea = m_regs[ins[7:5]];
      eb = m_regs[ins[4:2]];
      issue(ins, clr, rdy, ga, gb, gc, dn);
      n_checks++; if ({ga, gb, gc} !== {ea, eb, ins[15:11]}) begin n_fails++; $display("[TB] FAIL rand_issue[%0d]: got %h/%h/%h required %h/%h/%h", it, ga, gb, gc, ea, eb, ins[15:11]); end
      n_checks++; if (dn !== 3'b010) begin n_fails++; $display("[TB] FAIL rand_done[%0d]: got %b required 010", it, dn); end
      read_obs(ins[10:8], v);
      n_checks++; if (v !== m_regs[ins[10:8]]) begin n_fails++; $display("[TB] FAIL rand_rd[%0d]: got %h required %h", it, v, m_regs[ins[10:8]]); end
      n_checks++; if ({ovf_flag, ill_flag} !== {m_ovf, m_ill}) begin n_fails++; $display("[TB] FAIL rand_flags[%0d]: got %b required %b", it, {ovf_flag, ill_flag}, {m_ovf, m_ill}); end
    end
  endtask

  initial begin
    $display("[TB] starting alu_issue_ctrl bench");
    test_reset();
    test_add();
    test_overflow();
    test_illegal();
    test_back_to_back();
    test_ld_rules();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
